ras_stack: RTL
==============

# ras_stack

Return address stack for the branch prediction unit. It sits between the fetch-side predictor, which pushes and pops speculatively, and the branch feedback stage, whose resolved `bpu_update_t` fields drive a committed copy of the stack. A feedback flush, whether from a branch mispredict or a CSR redirect, restores the speculative stack from the committed copy in one cycle. The predictor uses the top entry as the target for `_RETURN`-typed branches.

## Interface
- `DEPTH`, default 8: number of entries; must be a power of two, ≥2.
- `clk`  in  1: clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `pred_push_i`  in  1: predictor saw a call; push `pred_push_addr_i`.
- `pred_pop_i`  in  1: predictor saw a return; pop the top entry.
- `pred_push_addr_i`  in  30: word address of the return point (call pc + 1 word).
- `upd_valid_i`  in  1: feedback stage retires a non-stalled, valid branch this cycle.
- `upd_taken_i`  in  1: resolved taken (`br_taken`).
- `upd_br_type_i`  in  2: `_CALL` / `_RETURN` / `_ABSOLUTE` / `_PC_RELATIVE` (bpu.svh encoding).
- `upd_pc_i`  in  30: word pc of the retiring branch (`pc`).
- `upd_flush_i`  in  1: feedback flush (`flush`); squash speculative state.
- `top_o`  out  30: speculative top-of-stack word address.
- `top_valid_o`  out  1: speculative stack is non-empty.

## Operation
- There are two identical stacks, speculative (S) and committed (C). Each has `DEPTH`×30 entries, a `$clog2(DEPTH)`-bit top pointer `ptr`, and a count `cnt` of width `$clog2(DEPTH)+1` that saturates at `DEPTH`.
- `top` = entry[ptr]. A push is `ptr+1` (mod DEPTH), then write, then `cnt = min(cnt+1, DEPTH)`. A pop is `ptr-1` (mod DEPTH), then `cnt-1`.
- Overflow: pushing while `cnt==DEPTH` wraps and overwrites the oldest entry; `cnt` stays at `DEPTH`.
- Underflow: popping while `cnt==0` is ignored; `ptr` and `cnt` are unchanged.
- Committed-stack update, applied when `upd_valid_i & upd_taken_i`:
  - `_CALL`: push `upd_pc_i + 30'd1`, with 30-bit wrap.
  - `_RETURN`: pop.
  - Other types: no change.
  - When `upd_valid_i=0` or `upd_taken_i=0`, C is unchanged.
- Speculative-stack update:
  - When `upd_flush_i=1`: S takes the *next* value of C, including any commit applied in the same cycle. Predictor push/pop in that cycle is discarded.
  - Otherwise, with `pred_pop_i` and `pred_push_i` both set: overwrite entry[ptr] with `pred_push_addr_i`; `ptr` unchanged; `cnt` unchanged, or 1 if it was 0.
  - Otherwise, only `pred_push_i`: push. Only `pred_pop_i`: pop.
- Outputs: `top_o = S.entry[S.ptr]`, `top_valid_o = (S.cnt != 0)`. Both are driven combinationally from registers only, with no input-to-output path.

## Timing
- Reset, applied while `rst_n=0` sampled at an edge: all entries, pointers and counts are 0, so `top_o=0` and `top_valid_o=0`. Reset overrides every other input in the same cycle. A reset asserted mid-sequence discards all state.
- Push or pop sampled at edge N is visible on `top_o`/`top_valid_o` after edge N, i.e. in cycle N+1. Latency is 1 cycle.
- A flush sampled at edge N makes cycle N+1 outputs reflect the committed state. This is a single-cycle restore with no bubble beyond that cycle.
- A commit and a flush in the same cycle: the commit is applied first, then S is copied from the updated C.
- There is no backpressure; every input is accepted every cycle.

## Test plan
- **Reset and empty pop:** reset, then `pred_pop_i=1` for 2 cycles. Expect `top_valid_o=0` and `top_o=0` throughout; a subsequent push of 0x100 gives `top_o=0x100` and `top_valid_o=1` next cycle.
- **Push/pop ordering:** push 0x10, 0x20, 0x30 on consecutive cycles, then pop twice. Expect `top_o` to read 0x10, 0x20, 0x30, 0x20, 0x10 in successive cycles; one more pop gives `top_valid_o=0`.
- **Overflow (DEPTH=8):** push 0x1 through 0x9. Expect `top_o=0x9`; after 7 pops `top_o=0x2` and `top_valid_o=1`; after an 8th pop `top_valid_o=0` (0x1 was lost).
- **Flush restore:**
  - Step 1: commit a `_CALL` with `upd_pc_i=0x40`, taken; speculatively push 0x41 and 0x77.
  - Step 2: assert `upd_flush_i` alone.
  - Expect next cycle `top_o=0x41`, and the next pop gives `top_valid_o=0`.
- **Same-cycle commit + flush + predict:** the committed stack holds 0x41. In one cycle assert `_RETURN` commit (taken), `upd_flush_i`, and `pred_push_i` with 0x99. Expect `top_valid_o=0` next cycle; the push is dropped.
- **Non-taken / non-call commits and simultaneous push+pop:**
  - Commit `_CALL` with `upd_taken_i=0`, then `_ABSOLUTE` taken, then flush. Expect C unchanged.
  - `pred_push_i` and `pred_pop_i` together with top 0x20 and addr 0x55. Expect `top_o=0x55` and the depth unchanged.

Source files
------------

// File: rtl/ras_stack.sv
`default_nettype none
// ============================================================================
//  Module   : ras_stack
//  Brief    : Return address stack with a speculative copy driven by the
//             predictor and a committed copy driven by branch feedback.
//  Revision : 1.0 - initial release
// ============================================================================
module ras_stack #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pred_push_i,
    input  logic        pred_pop_i,
    input  logic [29:0] pred_push_addr_i,
    input  logic        upd_valid_i,
    input  logic        upd_taken_i,
    input  logic [1:0]  upd_br_type_i,
    input  logic [29:0] upd_pc_i,
    input  logic        upd_flush_i,
    output logic [29:0] top_o,
    output logic        top_valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_FULL      = CNT_W'(DEPTH);
    localparam logic [1:0]       C_BR_CALL   = 2'd0;
    localparam logic [1:0]       C_BR_RETURN = 2'd1;

    logic [29:0]      c_mem_q [DEPTH];
    logic [29:0]      c_mem_d [DEPTH];
    logic [PTR_W-1:0] c_ptr_q, c_ptr_d;
    logic [CNT_W-1:0] c_cnt_q, c_cnt_d;

    logic [29:0]      s_mem_q [DEPTH];
    logic [29:0]      s_mem_d [DEPTH];
    logic [PTR_W-1:0] s_ptr_q, s_ptr_d;
    logic [CNT_W-1:0] s_cnt_q, s_cnt_d;

    logic [PTR_W-1:0] w_c_ptr_inc;
    logic [PTR_W-1:0] w_s_ptr_inc;

    assign w_c_ptr_inc = c_ptr_q + PTR_W'(1);
    assign w_s_ptr_inc = s_ptr_q + PTR_W'(1);

    // Committed stack: only taken, retiring calls and returns move it.
    always_comb begin
        c_mem_d = c_mem_q;
        c_ptr_d = c_ptr_q;
        c_cnt_d = c_cnt_q;
        if (upd_valid_i && upd_taken_i) begin
            case (upd_br_type_i)
                C_BR_CALL: begin
                    c_ptr_d              = w_c_ptr_inc;
                    c_mem_d[w_c_ptr_inc] = upd_pc_i + 30'd1;
                    if (c_cnt_q != C_FULL) begin
                        c_cnt_d = c_cnt_q + CNT_W'(1);
                    end
                end
                C_BR_RETURN: begin
                    if (c_cnt_q != '0) begin
                        c_ptr_d = c_ptr_q - PTR_W'(1);
                        c_cnt_d = c_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Speculative stack: a flush copies the post-commit committed state.
    always_comb begin
        s_mem_d = s_mem_q;
        s_ptr_d = s_ptr_q;
        s_cnt_d = s_cnt_q;
        if (upd_flush_i) begin
            s_mem_d = c_mem_d;
            s_ptr_d = c_ptr_d;
            s_cnt_d = c_cnt_d;
        end else if (pred_push_i && pred_pop_i) begin
            s_mem_d[s_ptr_q] = pred_push_addr_i;
            if (s_cnt_q == '0) begin
                s_cnt_d = CNT_W'(1);
            end
        end else if (pred_push_i) begin
            s_ptr_d              = w_s_ptr_inc;
            s_mem_d[w_s_ptr_inc] = pred_push_addr_i;
            if (s_cnt_q != C_FULL) begin
                s_cnt_d = s_cnt_q + CNT_W'(1);
            end
        end else if (pred_pop_i) begin
            if (s_cnt_q != '0) begin
                s_ptr_d = s_ptr_q - PTR_W'(1);
                s_cnt_d = s_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                c_mem_q[i] <= '0;
                s_mem_q[i] <= '0;
            end
            c_ptr_q <= '0;
            c_cnt_q <= '0;
            s_ptr_q <= '0;
            s_cnt_q <= '0;
        end else begin
            c_mem_q <= c_mem_d;
            c_ptr_q <= c_ptr_d;
            c_cnt_q <= c_cnt_d;
            s_mem_q <= s_mem_d;
            s_ptr_q <= s_ptr_d;
            s_cnt_q <= s_cnt_d;
        end
    end

    assign top_o       = s_mem_q[s_ptr_q];
    assign top_valid_o = (s_cnt_q != '0);

endmodule
`default_nettype wire
